md_unit: RTL and testbench
==========================

# md_unit

Execute-stage multiply/divide unit for the pipelined MIPS core. It accepts MULT/MULTU/DIV/DIVU with a one-cycle start, holds busy for a fixed latency, then commits the result into its HI/LO registers. It services MTHI/MTLO writes and the MFHI/MFLO read path. The value it returns on `HL_data` travels E→M→W and is written back by the W stage. Hazard logic stalls the pipeline on `start | busy` whenever D holds an md-class instruction.

## Interface
Parameters:
- `MULT_CYCLES`, 5: busy duration for MULT/MULTU.
- `DIV_CYCLES`, 10: busy duration for DIV/DIVU.

Ports:
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  reset; synchronous and active-high.
- `start`  in  1  one-cycle pulse launching the operation on `md_op`. Valid only with `md_op` 1–4.
- `md_op`  in  4  operation code: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO. Codes 9–15 behave as 0.
- `rs_data`  in  32  operand A (dividend / multiplicand / MTxx source).
- `rt_data`  in  32  operand B (divisor / multiplier).
- `busy`  out  1  registered; high while an operation is in flight.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.
- `HL_data`  out  32  combinational: `hi` when `md_op`=7, `lo` when `md_op`=8, else 0.

## Operation
- State: `hi`, `lo`, `busy`, 4-bit down-counter `cnt`, pending result `p_hi`/`p_lo`, pending-commit flag `p_wr`.
- Idle (`busy`=0):
  - `start` with op 1–4: operands are sampled, the result is computed into `p_hi`/`p_lo`, `cnt` loads MULT_CYCLES or DIV_CYCLES, and `busy` goes to 1.
- Busy: `cnt` decrements each edge. On the edge where `cnt` goes 1→0:
  - `busy` goes to 0.
  - If `p_wr`=1, `hi`/`lo` load `p_hi`/`p_lo`.
- MULT: {hi,lo} = signed(rs) × signed(rt), 64-bit. MULTU: same, unsigned.
- DIV: lo = signed quotient truncated toward zero; hi = remainder with the dividend's sign. DIVU: unsigned.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Divisor zero (DIV or DIVU): the op still busies for DIV_CYCLES with `p_wr`=0; hi/lo are unchanged.
- MTHI/MTLO while idle: `hi`/`lo` loads `rs_data` on the edge where `md_op`=5/6. They need no `start` and do not raise `busy`.
- Ignored inputs:
  - `start` while busy: no effect on `cnt`, `p_*` or `busy`.
  - MTHI/MTLO while busy: no effect.
  - `start` with `md_op` outside 1–4: no effect.
- MFHI/MFLO: purely combinational read of current hi/lo. While busy, this is the old value; hazard logic prevents its use.

## Timing
- Reset (edge with `rst`=1): hi=0, lo=0, busy=0, cnt=0, p_hi=p_lo=0, p_wr=0, `HL_data`=0 for md_op∉{7,8}.
- Reset mid-operation aborts it: the pending result is discarded and hi/lo become 0. `rst` takes priority over `start` and MTxx.
- `start` sampled at edge t0:
  - `busy`=1 from after t0 through edge t0+N, where N = MULT_CYCLES or DIV_CYCLES.
  - `busy`=0 and new hi/lo are visible after edge t0+N.
  - `busy` is high for exactly N cycles.
- `busy` is not asserted in the cycle `start` is high. The external stall uses `start|busy`.
- Back-to-back: a new `start` is accepted in the cycle immediately after `busy` falls, i.e. sampled at edge t0+N+1.
- MTHI/MTLO: one-edge latency. Value readable via MFHI/MFLO in the following cycle.
- `HL_data`: zero-cycle combinational path from `md_op`/hi/lo.

## Test plan
- Reset, then MULT rs=0xFFFFFFFF rt=0x00000002 → busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE. MFLO gives `HL_data`=0xFFFFFFFE.
- MULTU, same operands → hi=0x00000001, lo=0xFFFFFFFE after 5 cycles.
- DIV rs=0xFFFFFFF9 (−7), rt=2 → busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 → lo=3, hi=1.
- MTHI 0x12345678, then DIVU 5/0 → busy 10 cycles; hi stays 0x12345678, lo unchanged. Then DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- During a DIV:
  - At cycle 3, pulse `start` with MULT and drive MTLO 0xAAAA → both ignored; original DIV result commits at cycle 10.
  - MULT issued the cycle after `busy` falls → accepted.
- Start MULT, assert `rst` on busy cycle 2 → busy=0, hi=lo=0 next cycle; no commit afterwards.

Source files
------------

// File: rtl/md_unit.sv
// Execute-stage multiply/divide unit: MULT/MULTU/DIV/DIVU with fixed busy latency,
// HI/LO architectural registers, MTHI/MTLO writes and the MFHI/MFLO read mux.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] HL_data
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] p_hi_q, p_hi_d, p_lo_q, p_lo_d;
  logic        p_wr_q, p_wr_d;
  logic        busy_q, busy_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        is_mul, is_div, launch;
  logic [63:0] result;

  // Full 64-bit product; signed operands are sign-extended before multiplying.
  function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                        input logic is_signed);
    logic signed [63:0] sa, sb;
    logic [63:0]        ua, ub;
    if (is_signed) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return sa * sb;
    end else begin
      ua = {32'd0, a};
      ub = {32'd0, b};
      return ua * ub;
    end
  endfunction

  // Returns {remainder, quotient}. The INT_MIN / -1 overflow wraps to INT_MIN, remainder 0.
  // A zero divisor yields 0; the caller never commits that result.
  function automatic logic [63:0] div64(input logic [31:0] a, input logic [31:0] b,
                                        input logic is_signed);
    logic signed [31:0] sa, sb, sq, sr;
    if (b == 32'd0) begin
      return 64'd0;
    end else if (is_signed) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        return {32'd0, 32'h8000_0000};
      end
      sa = a;
      sb = b;
      sq = sa / sb;
      sr = sa % sb;
      return {sr, sq};
    end else begin
      return {a % b, a / b};
    end
  endfunction

  assign is_mul = (md_op == OP_MULT) || (md_op == OP_MULTU);
  assign is_div = (md_op == OP_DIV)  || (md_op == OP_DIVU);
  assign launch = start && !busy_q && (is_mul || is_div);

  always_comb begin
    result = 64'd0;
    if (is_mul) begin
      result = mul64(rs_data, rt_data, md_op == OP_MULT);
    end else if (is_div) begin
      result = div64(rs_data, rt_data, md_op == OP_DIV);
    end
  end

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    p_hi_d = p_hi_q;
    p_lo_d = p_lo_q;
    p_wr_d = p_wr_q;
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (busy_q) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        busy_d = 1'b0;
        p_wr_d = 1'b0;
        if (p_wr_q) begin
          hi_d = p_hi_q;
          lo_d = p_lo_q;
        end
      end
    end else if (launch) begin
      p_hi_d = result[63:32];
      p_lo_d = result[31:0];
      p_wr_d = is_mul || (rt_data != 32'd0);
      cnt_d  = is_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
      busy_d = 1'b1;
    end else if (md_op == OP_MTHI) begin
      hi_d = rs_data;
    end else if (md_op == OP_MTLO) begin
      lo_d = rs_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      p_hi_q <= 32'd0;
      p_lo_q <= 32'd0;
      p_wr_q <= 1'b0;
      busy_q <= 1'b0;
      cnt_q  <= 4'd0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      p_hi_q <= p_hi_d;
      p_lo_q <= p_lo_d;
      p_wr_q <= p_wr_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy    = busy_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign HL_data = (md_op == OP_MFHI) ? hi_q :
                   (md_op == OP_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed scenarios plus randomized op sequences
// compared against a plain-arithmetic HI/LO model.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] rs_data, rt_data;
  logic        busy;
  logic [31:0] hi, lo, HL_data;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] m_hi, m_lo;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .rst(rst), .start(start), .md_op(md_op),
    .rs_data(rs_data), .rt_data(rt_data),
    .busy(busy), .hi(hi), .lo(lo), .HL_data(HL_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: {hi,lo} an op should produce, plus whether it writes at all.
  function automatic logic [64:0] model_op(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      4'd1: begin q = sa * sb; return {1'b1, q[63:0]}; end
      4'd2: begin p = ua * ub; return {1'b1, p[63:0]}; end
      4'd3: begin
        if (b == 0) return 65'd0;
        q = sa / sb; r = sa % sb;
        return {1'b1, r[31:0], q[31:0]};
      end
      4'd4: begin
        if (b == 0) return 65'd0;
        p = ua / ub; q = longint'(ua % ub);
        return {1'b1, q[31:0], p[31:0]};
      end
      default: return 65'd0;
    endcase
  endfunction

  // Issues a start and counts busy cycles; fixes the model. Bounded wait.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cyc);
    logic [64:0] r;
    r = model_op(op, a, b);
    if (r[64]) begin m_hi = r[63:32]; m_lo = r[31:0]; end
    start = 1'b1; md_op = op; rs_data = a; rt_data = b;
    tick();
    start = 1'b0; md_op = 4'd0;
    cyc = 0;
    while (busy && cyc < 40) begin
      cyc++;
      tick();
    end
  endtask

  task automatic mtx(input logic [3:0] op, input logic [31:0] v);
    md_op = op; rs_data = v;
    if (op == 4'd5) m_hi = v; else m_lo = v;
    tick();
    md_op = 4'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    m_hi = 0; m_lo = 0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
    n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi got %h want 0", hi); end
    n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo got %h want 0", lo); end
    n_checks++; if (HL_data !== 32'd0) begin n_fail++; $display("FAIL reset_hl got %h want 0", HL_data); end
  endtask

  task automatic test_mult();
    int cyc;
    start = 1'b1; md_op = 4'd1; rs_data = 32'hFFFF_FFFF; rt_data = 32'd2;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_with_start got %0b want 0", busy); end
    start = 1'b0; md_op = 4'd0;
    run_op(4'd1, 32'hFFFF_FFFF, 32'd2, cyc);
    n_checks++; if (cyc != 5) begin n_fail++; $display("FAIL mult_busy got %0d want 5", cyc); end
    n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi got %h want ffffffff", hi); end
    n_checks++; if (lo !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mult_lo got %h want fffffffe", lo); end
    md_op = 4'd8; #1;
    n_checks++; if (HL_data !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mflo got %h want fffffffe", HL_data); end
    md_op = 4'd0;
  endtask

  task automatic test_multu();
    int cyc;
    run_op(4'd2, 32'hFFFF_FFFF, 32'd2, cyc);
    n_checks++; if (cyc != 5) begin n_fail++; $display("FAIL multu_busy got %0d want 5", cyc); end
    n_checks++; if ({hi, lo} !== 64'h1_FFFF_FFFE) begin n_fail++; $display("FAIL multu_hilo got %h_%h want 00000001_fffffffe", hi, lo); end
  endtask

  task automatic test_div();
    int cyc;
    run_op(4'd3, 32'hFFFF_FFF9, 32'd2, cyc);
    n_checks++; if (cyc != 10) begin n_fail++; $display("FAIL div_busy got %0d want 10", cyc); end
    n_checks++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_lo got %h want fffffffd", lo); end
    n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_hi got %h want ffffffff", hi); end
    run_op(4'd4, 32'd7, 32'd2, cyc);
    n_checks++; if ({hi, lo} !== {32'd1, 32'd3}) begin n_fail++; $display("FAIL divu_hilo got %h_%h want 00000001_00000003", hi, lo); end
  endtask

  task automatic test_divzero();
    int cyc;
    logic [31:0] old_lo;
    mtx(4'd5, 32'h1234_5678);
    md_op = 4'd7; #1;
    n_checks++; if (HL_data !== 32'h1234_5678) begin n_fail++; $display("FAIL mthi_read got %h want 12345678", HL_data); end
    md_op = 4'd0;
    old_lo = m_lo;
    run_op(4'd4, 32'd5, 32'd0, cyc);
    n_checks++; if (cyc != 10) begin n_fail++; $display("FAIL div0_busy got %0d want 10", cyc); end
    n_checks++; if ({hi, lo} !== {32'h1234_5678, old_lo}) begin n_fail++; $display("FAIL div0_hilo got %h_%h want 12345678_%h", hi, lo, old_lo); end
    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    n_checks++; if ({hi, lo} !== {32'd0, 32'h8000_0000}) begin n_fail++; $display("FAIL div_ovf got %h_%h want 00000000_80000000", hi, lo); end
  endtask

  task automatic test_ignore_and_back_to_back();
    int cyc;
    logic [64:0] r;
    r = model_op(4'd3, 32'd100, 32'hFFFF_FFF9);
    m_hi = r[63:32]; m_lo = r[31:0];
    start = 1'b1; md_op = 4'd3; rs_data = 32'd100; rt_data = 32'hFFFF_FFF9;
    tick();
    start = 1'b0; md_op = 4'd0;
    cyc = 0;
    while (busy && cyc < 40) begin
      cyc++;
      if (cyc == 3) begin start = 1'b1; md_op = 4'd1; rs_data = 32'd9; rt_data = 32'd9; end
      else if (cyc == 4) begin start = 1'b0; md_op = 4'd6; rs_data = 32'h0000_AAAA; end
      else begin start = 1'b0; md_op = 4'd0; end
      tick();
    end
    md_op = 4'd0;
    n_checks++; if (cyc != 10) begin n_fail++; $display("FAIL ignore_busy got %0d want 10", cyc); end
    n_checks++; if ({hi, lo} !== {m_hi, m_lo}) begin n_fail++; $display("FAIL ignore_hilo got %h_%h want %h_%h", hi, lo, m_hi, m_lo); end
    run_op(4'd1, 32'h0001_0000, 32'h0003_0000, cyc);
    n_checks++; if (cyc != 5) begin n_fail++; $display("FAIL b2b_busy got %0d want 5", cyc); end
    n_checks++; if ({hi, lo} !== 64'h3_0000_0000) begin n_fail++; $display("FAIL b2b_hilo got %h_%h want 00000003_00000000", hi, lo); end
  endtask

  task automatic test_reset_mid();
    start = 1'b1; md_op = 4'd1; rs_data = 32'd7; rt_data = 32'd6;
    tick();
    start = 1'b0; md_op = 4'd0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_hi = 0; m_lo = 0;
    n_checks++; if ({busy, hi, lo} !== 65'd0) begin n_fail++; $display("FAIL rst_mid got busy=%0b %h_%h want 0 0_0", busy, hi, lo); end
    repeat (8) tick();
    n_checks++; if ({busy, hi, lo} !== 65'd0) begin n_fail++; $display("FAIL rst_nocommit got busy=%0b %h_%h want 0 0_0", busy, hi, lo); end
  endtask

  task automatic test_random();
    int cyc;
    logic [3:0] op;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(1, 15));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: a = 32'h8000_0000;
        3: b = 32'($urandom_range(1, 20));
        default: ;
      endcase
      if (op >= 4'd1 && op <= 4'd4) begin
        run_op(op, a, b, cyc);
        n_checks++; if (cyc != ((op <= 4'd2) ? 5 : 10)) begin n_fail++; $display("FAIL rnd_busy op=%0d got %0d", op, cyc); end
        n_checks++; if ({hi, lo} !== {m_hi, m_lo}) begin n_fail++; $display("FAIL rnd_hilo op=%0d a=%h b=%h got %h_%h want %h_%h", op, a, b, hi, lo, m_hi, m_lo); end
      end else if (op == 4'd5 || op == 4'd6) begin
        mtx(op, a);
        md_op = (op == 4'd5) ? 4'd7 : 4'd8; #1;
        n_checks++; if (HL_data !== a) begin n_fail++; $display("FAIL rnd_mtx op=%0d got %h want %h", op, HL_data, a); end
        md_op = 4'd0;
      end else begin
        md_op = op; #1;
        n_checks++;
        if (HL_data !== ((op == 4'd7) ? m_hi : (op == 4'd8) ? m_lo : 32'd0)) begin
          n_fail++; $display("FAIL rnd_hl op=%0d got %h hi=%h lo=%h", op, HL_data, m_hi, m_lo);
        end
        md_op = 4'd0;
        tick();
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; md_op = 4'd0; rs_data = 32'd0; rt_data = 32'd0;
    m_hi = 0; m_lo = 0;
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_divzero();
    test_ignore_and_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
